// File: rtl/arm_led_bus_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | arm_led_bus_if : ARM external-bus slave -> LED command word + watchdog      |
// | Option macro LED_BUS_READBACK_EN enables the register read path.            |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module arm_led_bus_if #(
   parameter logic [7:0]  BASE_ADDR = 8'h10,
   parameter int          TICK_DIV  = 50000,
   parameter logic [15:0] ID_VALUE  = 16'h4C45
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_arm_ncs,
   input  logic        i_arm_nwe,
   input  logic        i_arm_noe,
   input  logic [7:0]  i_arm_addr,
   input  logic [15:0] i_arm_data_in,
   output logic [15:0] o_arm_data_out,
   output logic        o_arm_data_oe,
   output logic [4:0]  o_arm_led_data,
   output logic        o_wdt_expired
);
   localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] c_PRE_MAX  = PW'(TICK_DIV - 1);
   localparam logic [7:0]    c_ADDR_CMD = BASE_ADDR;
   localparam logic [7:0]    c_ADDR_TMO = BASE_ADDR + 8'd1;
   localparam logic [7:0]    c_ADDR_STS = BASE_ADDR + 8'd2;
   localparam logic [7:0]    c_ADDR_ID  = BASE_ADDR + 8'd3;

   typedef enum logic [1:0] {S_IDLE, S_WR_ACT, S_WR_COMMIT, S_RD_ACT} state_t;

   state_t      r_state, w_state_nxt;
   logic [2:0]  r_ncs_s, r_nwe_s;
   logic [7:0]  r_addr_s1, r_addr_s2, r_wr_addr;
   logic [15:0] r_data_s1, r_data_s2, r_wr_data;
   logic        r_armed;
   logic [4:0]  r_led_cmd, r_led_out;
   logic [15:0] r_tmo, r_ticks;
   logic [PW-1:0] r_pre;
   logic        r_wdt;

   logic w_ncs, w_nwe, w_ncs_rise, w_nwe_rise;
   logic w_commit, w_wr_cmd, w_wr_tmo, w_wr_sts, w_tick, w_expire;

   assign w_ncs      = r_ncs_s[1];
   assign w_nwe      = r_nwe_s[1];
   assign w_ncs_rise = r_ncs_s[1] & ~r_ncs_s[2];
   assign w_nwe_rise = r_nwe_s[1] & ~r_nwe_s[2];

   // NCS sync resets low so an access already in flight at reset release is never armed.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ncs_s   <= 3'b000;
         r_nwe_s   <= 3'b111;
         r_addr_s1 <= 8'h00;
         r_addr_s2 <= 8'h00;
         r_data_s1 <= 16'h0000;
         r_data_s2 <= 16'h0000;
         r_armed   <= 1'b0;
      end else begin
         r_ncs_s   <= {r_ncs_s[1:0], i_arm_ncs};
         r_nwe_s   <= {r_nwe_s[1:0], i_arm_nwe};
         r_addr_s1 <= i_arm_addr;
         r_addr_s2 <= r_addr_s1;
         r_data_s1 <= i_arm_data_in;
         r_data_s2 <= r_data_s1;
         if (w_ncs) r_armed <= 1'b1;
      end
   end

`ifdef LED_BUS_READBACK_EN
   logic [2:0]  r_noe_s;
   logic        w_noe, w_noe_rise;
   assign w_noe      = r_noe_s[1];
   assign w_noe_rise = r_noe_s[1] & ~r_noe_s[2];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_noe_s <= 3'b111;
      else          r_noe_s <= {r_noe_s[1:0], i_arm_noe};
   end
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (r_armed && !w_ncs) begin
               if (!w_nwe) w_state_nxt = S_WR_ACT;
`ifdef LED_BUS_READBACK_EN
               else if (!w_noe) w_state_nxt = S_RD_ACT;
`endif
            end
         end
         S_WR_ACT: begin
            if (w_nwe_rise)      w_state_nxt = S_WR_COMMIT;
            else if (w_ncs_rise) w_state_nxt = S_IDLE;
         end
         S_WR_COMMIT: w_state_nxt = S_IDLE;
`ifdef LED_BUS_READBACK_EN
         S_RD_ACT: if (w_noe_rise || w_ncs_rise) w_state_nxt = S_IDLE;
`endif
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_commit = (r_state == S_WR_COMMIT);
   assign w_wr_cmd = w_commit && (r_wr_addr == c_ADDR_CMD);
   assign w_wr_tmo = w_commit && (r_wr_addr == c_ADDR_TMO);
   assign w_wr_sts = w_commit && (r_wr_addr == c_ADDR_STS);
   assign w_tick   = (r_pre == c_PRE_MAX);
   assign w_expire = r_led_cmd[4] && (r_tmo != 16'h0000) && (r_ticks == r_tmo) && !w_wr_cmd;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_addr <= 8'h00;
         r_wr_data <= 16'h0000;
         r_led_cmd <= 5'h0F;
         r_led_out <= 5'h0F;
         r_tmo     <= 16'h0000;
         r_ticks   <= 16'h0000;
         r_pre     <= '0;
         r_wdt     <= 1'b0;
      end else begin
         if (r_state == S_WR_ACT) begin
            r_wr_addr <= r_addr_s2;
            r_wr_data <= r_data_s2;
         end
         r_led_out <= r_led_cmd;
         r_pre     <= w_tick ? '0 : r_pre + PW'(1);
         if (w_wr_tmo) r_tmo <= r_wr_data;
         if (w_wr_cmd)      r_led_cmd    <= r_wr_data[4:0];
         else if (w_expire) r_led_cmd[4] <= 1'b0;
         if (w_wr_cmd || (r_tmo == 16'h0000) || w_expire)
            r_ticks <= 16'h0000;
         else if (w_tick && (r_ticks != 16'hFFFF))
            r_ticks <= r_ticks + 16'd1;
         // Expiry takes precedence over a simultaneous flag clear.
         if (w_expire)                     r_wdt <= 1'b1;
         else if (w_wr_sts && r_wr_data[0]) r_wdt <= 1'b0;
      end
   end

   assign o_arm_led_data = r_led_out;
   assign o_wdt_expired  = r_wdt;

`ifdef LED_BUS_READBACK_EN
   logic [15:0] w_rd_mux, r_data_out;
   logic        r_oe;

   always_comb begin
      w_rd_mux = 16'h0000;
      case (r_addr_s2)
         c_ADDR_CMD: w_rd_mux = {11'd0, r_led_cmd};
         c_ADDR_TMO: w_rd_mux = r_tmo;
         c_ADDR_STS: w_rd_mux = {15'd0, r_wdt};
         c_ADDR_ID:  w_rd_mux = ID_VALUE;
         default:    w_rd_mux = 16'h0000;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_data_out <= 16'h0000;
         r_oe       <= 1'b0;
      end else begin
         if (r_state == S_IDLE && w_state_nxt == S_RD_ACT) r_data_out <= w_rd_mux;
         r_oe <= (r_state == S_RD_ACT) && (w_state_nxt == S_RD_ACT);
      end
   end

   assign o_arm_data_out = r_data_out;
   assign o_arm_data_oe  = r_oe;
`else
   logic w_unused;
   assign w_unused       = ^{i_arm_noe, ID_VALUE};
   assign o_arm_data_out = 16'h0000;
   assign o_arm_data_oe  = 1'b0;
`endif

endmodule
`default_nettype wire
